// File: rtl/axi_lite_master_arbiter.sv
// Two-master AXI4-Lite arbiter in front of the interconnect's single master port.
// Write and read paths each run an independent round-robin FSM and hold the grant for a whole transaction.
module axi_lite_master_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    // requester side, master k in bit/slice k
    input  logic [1:0]                  i_m_axi_awvalid,
    output logic [1:0]                  o_m_axi_awready,
    input  logic [2*ADDR_WIDTH-1:0]     i_m_axi_awaddr,
    input  logic [5:0]                  i_m_axi_awprot,
    input  logic [1:0]                  i_m_axi_wvalid,
    output logic [1:0]                  o_m_axi_wready,
    input  logic [2*DATA_WIDTH-1:0]     i_m_axi_wdata,
    input  logic [2*DATA_WIDTH/8-1:0]   i_m_axi_wstrb,
    output logic [1:0]                  o_m_axi_bvalid,
    input  logic [1:0]                  i_m_axi_bready,
    input  logic [1:0]                  i_m_axi_arvalid,
    output logic [1:0]                  o_m_axi_arready,
    input  logic [2*ADDR_WIDTH-1:0]     i_m_axi_araddr,
    input  logic [5:0]                  i_m_axi_arprot,
    output logic [1:0]                  o_m_axi_rvalid,
    input  logic [1:0]                  i_m_axi_rready,
    output logic [2*DATA_WIDTH-1:0]     o_m_axi_rdata,
    // interconnect side
    output logic                        o_s_axi_awvalid,
    output logic [ADDR_WIDTH-1:0]       o_s_axi_awaddr,
    output logic [2:0]                  o_s_axi_awprot,
    input  logic                        i_s_axi_awready,
    output logic                        o_s_axi_wvalid,
    output logic [DATA_WIDTH-1:0]       o_s_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]     o_s_axi_wstrb,
    input  logic                        i_s_axi_wready,
    input  logic                        i_s_axi_bvalid,
    output logic                        o_s_axi_bready,
    output logic                        o_s_axi_arvalid,
    output logic [ADDR_WIDTH-1:0]       o_s_axi_araddr,
    output logic [2:0]                  o_s_axi_arprot,
    input  logic                        i_s_axi_arready,
    input  logic                        i_s_axi_rvalid,
    input  logic [DATA_WIDTH-1:0]       i_s_axi_rdata,
    output logic                        o_s_axi_rready,
    output logic [1:0]                  o_wr_grant,
    output logic [1:0]                  o_rd_grant
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

    wr_state_t wr_state, wr_state_nxt;
    rd_state_t rd_state, rd_state_nxt;
    logic      wr_sel, wr_sel_nxt, wr_prio, wr_prio_nxt;
    logic      rd_sel, rd_sel_nxt, rd_prio, rd_prio_nxt;
    logic      aw_done, aw_done_nxt, w_done, w_done_nxt;
    logic      aw_hs, w_hs;

    // Contention goes to the priority pointer; a lone requester always wins.
    function automatic logic pick(input logic [1:0] req, input logic prio);
        return (req == 2'b11) ? prio : req[1];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            wr_prio  <= 1'b0;
            rd_prio  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
            wr_sel   <= wr_sel_nxt;
            rd_sel   <= rd_sel_nxt;
            wr_prio  <= wr_prio_nxt;
            rd_prio  <= rd_prio_nxt;
            aw_done  <= aw_done_nxt;
            w_done   <= w_done_nxt;
        end
    end

    // Write path: AW and W complete independently, B follows once both are done.
    always_comb begin
        wr_state_nxt    = wr_state;
        wr_sel_nxt      = wr_sel;
        wr_prio_nxt     = wr_prio;
        aw_done_nxt     = aw_done;
        w_done_nxt      = w_done;
        aw_hs           = 1'b0;
        w_hs            = 1'b0;
        o_m_axi_awready = '0;
        o_m_axi_wready  = '0;
        o_m_axi_bvalid  = '0;
        o_s_axi_awvalid = 1'b0;
        o_s_axi_awaddr  = '0;
        o_s_axi_awprot  = '0;
        o_s_axi_wvalid  = 1'b0;
        o_s_axi_wdata   = '0;
        o_s_axi_wstrb   = '0;
        o_s_axi_bready  = 1'b0;
        o_wr_grant      = '0;
        case (wr_state)
            W_IDLE: begin
                if (|i_m_axi_awvalid) begin
                    wr_sel_nxt   = pick(i_m_axi_awvalid, wr_prio);
                    wr_state_nxt = W_XFER;
                end
            end
            W_XFER: begin
                o_wr_grant[wr_sel]     = 1'b1;
                o_s_axi_awvalid        = i_m_axi_awvalid[wr_sel] & ~aw_done;
                o_s_axi_awaddr         = i_m_axi_awaddr[wr_sel*ADDR_WIDTH +: ADDR_WIDTH];
                o_s_axi_awprot         = i_m_axi_awprot[wr_sel*3 +: 3];
                o_s_axi_wvalid         = i_m_axi_wvalid[wr_sel] & ~w_done;
                o_s_axi_wdata          = i_m_axi_wdata[wr_sel*DATA_WIDTH +: DATA_WIDTH];
                o_s_axi_wstrb          = i_m_axi_wstrb[wr_sel*STRB_WIDTH +: STRB_WIDTH];
                o_m_axi_awready[wr_sel] = i_s_axi_awready & ~aw_done;
                o_m_axi_wready[wr_sel]  = i_s_axi_wready & ~w_done;
                aw_hs = i_m_axi_awvalid[wr_sel] & ~aw_done & i_s_axi_awready;
                w_hs  = i_m_axi_wvalid[wr_sel] & ~w_done & i_s_axi_wready;
                if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                    wr_state_nxt = W_RESP;
                    aw_done_nxt  = 1'b0;
                    w_done_nxt   = 1'b0;
                end else begin
                    aw_done_nxt  = aw_done | aw_hs;
                    w_done_nxt   = w_done | w_hs;
                end
            end
            W_RESP: begin
                o_wr_grant[wr_sel]     = 1'b1;
                o_m_axi_bvalid[wr_sel] = i_s_axi_bvalid;
                o_s_axi_bready         = i_m_axi_bready[wr_sel];
                if (i_s_axi_bvalid && i_m_axi_bready[wr_sel]) begin
                    wr_state_nxt = W_IDLE;
                    wr_prio_nxt  = ~wr_sel;
                end
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    // Read path: AR then R; the idle master's rdata slice is held at zero.
    always_comb begin
        rd_state_nxt    = rd_state;
        rd_sel_nxt      = rd_sel;
        rd_prio_nxt     = rd_prio;
        o_m_axi_arready = '0;
        o_m_axi_rvalid  = '0;
        o_m_axi_rdata   = '0;
        o_s_axi_arvalid = 1'b0;
        o_s_axi_araddr  = '0;
        o_s_axi_arprot  = '0;
        o_s_axi_rready  = 1'b0;
        o_rd_grant      = '0;
        case (rd_state)
            R_IDLE: begin
                if (|i_m_axi_arvalid) begin
                    rd_sel_nxt   = pick(i_m_axi_arvalid, rd_prio);
                    rd_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                o_rd_grant[rd_sel]      = 1'b1;
                o_s_axi_arvalid         = i_m_axi_arvalid[rd_sel];
                o_s_axi_araddr          = i_m_axi_araddr[rd_sel*ADDR_WIDTH +: ADDR_WIDTH];
                o_s_axi_arprot          = i_m_axi_arprot[rd_sel*3 +: 3];
                o_m_axi_arready[rd_sel] = i_s_axi_arready;
                if (i_m_axi_arvalid[rd_sel] && i_s_axi_arready)
                    rd_state_nxt = R_DATA;
            end
            R_DATA: begin
                o_rd_grant[rd_sel]     = 1'b1;
                o_m_axi_rvalid[rd_sel] = i_s_axi_rvalid;
                o_m_axi_rdata[rd_sel*DATA_WIDTH +: DATA_WIDTH] = i_s_axi_rdata;
                o_s_axi_rready         = i_m_axi_rready[rd_sel];
                if (i_s_axi_rvalid && i_m_axi_rready[rd_sel]) begin
                    rd_state_nxt = R_IDLE;
                    rd_prio_nxt  = ~rd_sel;
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// Directed bench for the two-master AXI4-Lite arbiter: arbitration table plus
// hand-written sequences for split AW/W, read latency and mid-transaction reset.
module tb_axi_lite_master_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
    logic [63:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [5:0]  m_awprot, m_arprot;
    logic [7:0]  m_wstrb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [2:0]  s_awprot, s_arprot;
    logic [3:0]  s_wstrb;
    logic [1:0]  wr_grant, rd_grant;

    int total = 0;
    int bad = 0;

    axi_lite_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_m_axi_awvalid(m_awvalid), .o_m_axi_awready(m_awready),
        .i_m_axi_awaddr(m_awaddr), .i_m_axi_awprot(m_awprot),
        .i_m_axi_wvalid(m_wvalid), .o_m_axi_wready(m_wready),
        .i_m_axi_wdata(m_wdata), .i_m_axi_wstrb(m_wstrb),
        .o_m_axi_bvalid(m_bvalid), .i_m_axi_bready(m_bready),
        .i_m_axi_arvalid(m_arvalid), .o_m_axi_arready(m_arready),
        .i_m_axi_araddr(m_araddr), .i_m_axi_arprot(m_arprot),
        .o_m_axi_rvalid(m_rvalid), .i_m_axi_rready(m_rready),
        .o_m_axi_rdata(m_rdata),
        .o_s_axi_awvalid(s_awvalid), .o_s_axi_awaddr(s_awaddr), .o_s_axi_awprot(s_awprot),
        .i_s_axi_awready(s_awready),
        .o_s_axi_wvalid(s_wvalid), .o_s_axi_wdata(s_wdata), .o_s_axi_wstrb(s_wstrb),
        .i_s_axi_wready(s_wready),
        .i_s_axi_bvalid(s_bvalid), .o_s_axi_bready(s_bready),
        .o_s_axi_arvalid(s_arvalid), .o_s_axi_araddr(s_araddr), .o_s_axi_arprot(s_arprot),
        .i_s_axi_arready(s_arready),
        .i_s_axi_rvalid(s_rvalid), .i_s_axi_rdata(s_rdata), .o_s_axi_rready(s_rready),
        .o_wr_grant(wr_grant), .o_rd_grant(rd_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] wreq;
        logic [1:0] exp_wg;
        logic [1:0] rreq;
        logic [1:0] exp_rg;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] a0, a1, d0, d1, r0, r1, rd;
    logic [31:0] exp_awaddr, exp_wdata, exp_araddr;
    logic [63:0] exp_rdata;

    initial begin
        // write prio: M0,M1,M0,M1,M0,M0 before each row; read prio: M0,M0,M1,M0,M1,M0
        vecs[0] = '{wreq: 2'b01, exp_wg: 2'b01, rreq: 2'b10, exp_rg: 2'b10};
        vecs[1] = '{wreq: 2'b11, exp_wg: 2'b10, rreq: 2'b11, exp_rg: 2'b01};
        vecs[2] = '{wreq: 2'b11, exp_wg: 2'b01, rreq: 2'b11, exp_rg: 2'b10};
        vecs[3] = '{wreq: 2'b10, exp_wg: 2'b10, rreq: 2'b01, exp_rg: 2'b01};
        vecs[4] = '{wreq: 2'b00, exp_wg: 2'b00, rreq: 2'b11, exp_rg: 2'b10};
        vecs[5] = '{wreq: 2'b11, exp_wg: 2'b01, rreq: 2'b00, exp_rg: 2'b00};

        m_awvalid = 0; m_wvalid = 0; m_bready = 0; m_arvalid = 0; m_rready = 0;
        m_awaddr = 0; m_wdata = 0; m_araddr = 0; m_awprot = 0; m_arprot = 0; m_wstrb = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0; s_rdata = 0;

        #1;
        chk("reset_wr_grant", 64'(wr_grant), 64'd0);
        chk("reset_rd_grant", 64'(rd_grant), 64'd0);
        chk("reset_s_valids", 64'({s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}), 64'd0);
        chk("reset_s_awaddr", 64'(s_awaddr), 64'd0);
        #16 reset_n = 1'b1;
        cyc();

        for (int i = 0; i < 6; i++) begin
            a0 = 32'h0000_0010 + 32'(i * 16);  a1 = 32'h0100_0000 + 32'(i * 16);
            d0 = 32'hDEAD_BEEF ^ 32'(i);       d1 = 32'hB000_0000 + 32'(i);
            r0 = 32'h0100_0004 + 32'(i * 4);   r1 = 32'h2000_0000 + 32'(i * 4);
            rd = 32'h1234_5678 + 32'(i);
            m_awaddr = {a1, a0}; m_wdata = {d1, d0}; m_wstrb = 8'hF3; m_awprot = 6'b101_010;
            m_araddr = {r1, r0}; m_arprot = 6'b011_100;
            m_awvalid = vecs[i].wreq; m_wvalid = vecs[i].wreq; m_arvalid = vecs[i].rreq;
            s_awready = 1; s_wready = 1; s_arready = 1;
            exp_awaddr = (vecs[i].exp_wg == 2'b00) ? 32'd0 : (vecs[i].exp_wg[1] ? a1 : a0);
            exp_wdata  = (vecs[i].exp_wg == 2'b00) ? 32'd0 : (vecs[i].exp_wg[1] ? d1 : d0);
            exp_araddr = (vecs[i].exp_rg == 2'b00) ? 32'd0 : (vecs[i].exp_rg[1] ? r1 : r0);
            exp_rdata  = vecs[i].exp_rg[1] ? {rd, 32'd0} : (vecs[i].exp_rg[0] ? {32'd0, rd} : 64'd0);
            #1;
            chk($sformatf("v%0d_no_early_grant", i), 64'({wr_grant, rd_grant}), 64'd0);
            cyc();
            #1;
            chk($sformatf("v%0d_wr_grant", i), 64'(wr_grant), 64'(vecs[i].exp_wg));
            chk($sformatf("v%0d_rd_grant", i), 64'(rd_grant), 64'(vecs[i].exp_rg));
            chk($sformatf("v%0d_awaddr", i), 64'(s_awaddr), 64'(exp_awaddr));
            chk($sformatf("v%0d_wdata", i), 64'(s_wdata), 64'(exp_wdata));
            chk($sformatf("v%0d_araddr", i), 64'(s_araddr), 64'(exp_araddr));
            chk($sformatf("v%0d_m_awready", i), 64'(m_awready), 64'(vecs[i].exp_wg));
            chk($sformatf("v%0d_m_arready", i), 64'(m_arready), 64'(vecs[i].exp_rg));
            cyc();
            m_awvalid &= ~vecs[i].exp_wg; m_wvalid &= ~vecs[i].exp_wg; m_arvalid &= ~vecs[i].exp_rg;
            s_bvalid = 1; m_bready = 2'b11; s_rvalid = 1; s_rdata = rd; m_rready = 2'b11;
            #1;
            chk($sformatf("v%0d_s_awvalid_after", i), 64'(s_awvalid), 64'd0);
            chk($sformatf("v%0d_m_bvalid", i), 64'(m_bvalid), 64'(vecs[i].exp_wg));
            chk($sformatf("v%0d_m_rvalid", i), 64'(m_rvalid), 64'(vecs[i].exp_rg));
            chk($sformatf("v%0d_m_rdata", i), m_rdata, exp_rdata);
            cyc();
            s_bvalid = 0; s_rvalid = 0; m_bready = 0; m_rready = 0;
            m_awvalid = 0; m_wvalid = 0; m_arvalid = 0;
            #1;
            chk($sformatf("v%0d_idle_grants", i), 64'({wr_grant, rd_grant}), 64'd0);
        end

        // Split AW/W from M1 (write prio now M1) while M0 also requests.
        m_awaddr = {32'h0100_0000, 32'h0000_0000}; m_wdata = {32'hCAFE_F00D, 32'h1111_1111};
        m_awvalid = 2'b11; m_wvalid = 2'b10; s_awready = 0; s_wready = 0;
        cyc();
        #1;
        chk("split_grant_m1", 64'(wr_grant), 64'h2);
        chk("split_s_awaddr", 64'(s_awaddr), 64'h0100_0000);
        chk("split_s_valids", 64'({s_awvalid, s_wvalid}), 64'h3);
        chk("split_c0_readys", 64'({m_awready, m_wready}), 64'h0);
        cyc();
        s_bvalid = 1;
        #1;
        chk("split_c1_readys", 64'({m_awready, m_wready}), 64'h0);
        chk("split_no_early_b", 64'(m_bvalid), 64'h0);
        cyc();
        s_awready = 1;
        #1;
        chk("split_c2_awready", 64'({m_awready, m_wready}), 64'b10_00);
        cyc();
        s_wready = 1;
        #1;
        chk("split_aw_done_valid", 64'(s_awvalid), 64'h0);
        chk("split_c3_readys", 64'({m_awready, m_wready}), 64'b00_10);
        chk("split_still_xfer", 64'({wr_grant, m_bvalid}), 64'b10_00);
        cyc();
        m_awvalid = 2'b01; m_wvalid = 2'b00; m_bready = 2'b10; s_awready = 0; s_wready = 0;
        #1;
        chk("split_resp_bvalid", 64'(m_bvalid), 64'h2);
        chk("split_resp_bready", 64'({s_bready, s_wvalid}), 64'b10);
        cyc();
        s_bvalid = 0; m_bready = 0;
        #1;
        chk("split_back_idle", 64'(wr_grant), 64'h0);
        cyc();
        #1;
        chk("pending_m0_grant", 64'(wr_grant), 64'h1);

        // M0 read with 4-cycle data latency, concurrent with the M0 write above.
        m_araddr = {32'h0, 32'h0100_0004}; m_arvalid = 2'b01; s_arready = 1;
        m_wvalid = 2'b01; s_awready = 1; s_wready = 1;
        cyc();
        m_awvalid = 0; m_wvalid = 0;
        #1;
        chk("rd_grant_m0", 64'(rd_grant), 64'h1);
        chk("rd_araddr", 64'(s_araddr), 64'h0100_0004);
        cyc();
        m_arvalid = 0; s_arready = 0; m_rready = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("rd_wait%0d_rvalid", k), 64'({m_rvalid, rd_grant}), 64'b00_01);
            cyc();
        end
        s_rvalid = 1; s_rdata = 32'h1234_5678;
        #1;
        chk("rd_slow_rdata", m_rdata, 64'h0000_0000_1234_5678);
        chk("rd_slow_rready", 64'({s_rready, m_rvalid}), 64'b1_01);
        cyc();
        s_rvalid = 0; m_rready = 0;
        s_bvalid = 1; m_bready = 2'b00;
        #1;
        chk("rd_done_idle", 64'(rd_grant), 64'h0);
        chk("wr_resp_hold", 64'({wr_grant, m_bvalid, s_bready}), 64'b01_01_0);

        // Asynchronous reset in W_RESP.
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_grant", 64'(wr_grant), 64'h0);
        chk("rst_mid_bvalid", 64'({m_bvalid, s_bready}), 64'h0);
        #2 reset_n = 1'b1;
        s_bvalid = 0;
        m_wvalid = 2'b01;
        cyc();
        #1;
        chk("wvalid_only_no_grant", 64'(wr_grant), 64'h0);
        m_wvalid = 2'b10; m_awvalid = 2'b10; m_awaddr = {32'h0100_0040, 32'h0};
        cyc();
        #1;
        chk("post_rst_m1_grant", 64'(wr_grant), 64'h2);
        chk("post_rst_awaddr", 64'(s_awaddr), 64'h0100_0040);
        cyc();
        m_awvalid = 0; m_wvalid = 0; s_bvalid = 1; m_bready = 2'b10;
        #1;
        chk("post_rst_bvalid", 64'(m_bvalid), 64'h2);
        cyc();
        s_bvalid = 0; m_bready = 0;
        #1;
        chk("post_rst_idle", 64'(wr_grant), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
